// File: rtl/lut_layer_sequencer.sv
// Time-multiplexed layer of 6-input LUT neurons: one shared 64:1 lookup walks
// the neurons one per cycle and presents the whole result vector with a handshake.
module lut_layer_sequencer #(
  parameter int N_NEURONS = 8,
  parameter int FAN_IN    = 6,
  localparam int AW       = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cfg_we,
  input  logic [AW-1:0]                 cfg_addr,
  input  logic [63:0]                   cfg_data,
  output logic                          cfg_ready,
  input  logic                          in_valid,
  input  logic [FAN_IN*N_NEURONS-1:0]   in_data,
  output logic                          in_ready,
  output logic                          out_valid,
  output logic [N_NEURONS-1:0]          out_data,
  input  logic                          out_ready
);

  localparam int TT = 1 << FAN_IN;
  localparam logic [AW-1:0] LAST = AW'(N_NEURONS - 1);

  typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

  state_t                        state, state_nxt;
  logic [TT-1:0]                 tables [N_NEURONS];
  logic [FAN_IN*N_NEURONS-1:0]   in_reg;
  logic [AW-1:0]                 idx;
  logic [FAN_IN-1:0]             sel;
  logic                          lut_bit;
  logic                          cfg_hit;

  assign in_ready  = (state == IDLE);
  assign cfg_ready = (state == IDLE);
  assign out_valid = (state == DONE);

  // Widened compare so out-of-range addresses are rejected even when N_NEURONS is not a power of two.
  assign cfg_hit = cfg_we && cfg_ready && ({1'b0, cfg_addr} < (AW+1)'(N_NEURONS));

  assign sel     = in_reg[FAN_IN*idx +: FAN_IN];
  assign lut_bit = tables[idx][sel];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid) state_nxt = EVAL;
      EVAL: if (idx == LAST) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Table writes land on the accept edge, so a vector accepted alongside a write sees the new table.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_NEURONS; k++) begin
        tables[k] <= '0;
      end
      in_reg   <= '0;
      idx      <= '0;
      out_data <= '0;
    end else begin
      if (cfg_hit) begin
        tables[cfg_addr] <= cfg_data;
      end
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_reg   <= in_data;
            out_data <= '0;
            idx      <= '0;
          end
        end
        EVAL: begin
          out_data[idx] <= lut_bit;
          if (idx != LAST) begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lut_layer_sequencer.sv
// Directed and randomized bench for lut_layer_sequencer; a second, five-neuron
// instance exercises out-of-range config addresses that a 3-bit port can express.
module tb_lut_layer_sequencer;

  localparam int N  = 8;
  localparam int N5 = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [63:0] cfg_data;
  logic        cfg_ready;
  logic        in_valid;
  logic [47:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;

  logic        s_cfg_we;
  logic [2:0]  s_cfg_addr;
  logic [63:0] s_cfg_data;
  logic        s_cfg_ready;
  logic        s_in_valid;
  logic [29:0] s_in_data;
  logic        s_in_ready;
  logic        s_out_valid;
  logic [4:0]  s_out_data;
  logic        s_out_ready;

  int checks = 0;
  int errors = 0;
  int hs_count = 0;
  logic [63:0] mtab [N];

  assign s_out_ready = 1'b1;

  always #5 clk = ~clk;

  lut_layer_sequencer #(.N_NEURONS(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_ready(cfg_ready),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
  );

  lut_layer_sequencer #(.N_NEURONS(N5)) dut5 (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(s_cfg_we), .cfg_addr(s_cfg_addr), .cfg_data(s_cfg_data), .cfg_ready(s_cfg_ready),
    .in_valid(s_in_valid), .in_data(s_in_data), .in_ready(s_in_ready),
    .out_valid(s_out_valid), .out_data(s_out_data), .out_ready(s_out_ready)
  );

  always @(posedge clk) begin
    if (out_valid && out_ready) hs_count++;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [7:0] model_eval(input logic [47:0] v);
    logic [7:0] r;
    r = '0;
    for (int k = 0; k < N; k++) r[k] = mtab[k][v[6*k +: 6]];
    return r;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; cfg_we = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    s_cfg_we = 1'b0; s_in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < N; k++) mtab[k] = '0;
  endtask

  task automatic write_cfg(input logic [2:0] a, input logic [63:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    @(negedge clk);
    cfg_we = 1'b0;
    mtab[a] = d;
  endtask

  // Offers one vector (optionally with a same-edge table write); lat is edges from accept to out_valid, -1 on timeout.
  task automatic run_vector(input logic [47:0] v, input bit cw, input logic [2:0] ca,
                            input logic [63:0] cd, input bit rel,
                            output logic [7:0] res, output int lat);
    int w;
    w = 0;
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    in_valid = 1'b1; in_data = v; cfg_we = cw; cfg_addr = ca; cfg_data = cd;
    lat = -1;
    res = 'x;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (c == 0) begin
        in_valid = 1'b0; cfg_we = 1'b0; in_data = ~v;
      end
      if (out_valid) begin
        lat = c;
        res = out_data;
        break;
      end
    end
    if (rel && lat >= 0) begin
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cfg_we = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    cfg_addr = '0; cfg_data = '0;
    s_cfg_we = 1'b0; s_in_valid = 1'b0; s_cfg_addr = '0; s_cfg_data = '0; s_in_data = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got valid=%b data=%h expected valid=0 data=00", out_valid, out_data);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || cfg_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_ready: got in_ready=%b cfg_ready=%b expected 1 1", in_ready, cfg_ready);
    end
    for (int k = 0; k < N; k++) mtab[k] = '0;
  endtask

  task automatic test_no_config();
    logic [7:0] res;
    int lat;
    run_vector('1, 1'b0, 3'd0, 64'd0, 1'b1, res, lat);
    checks++;
    if (lat != 8) begin
      errors++;
      $display("[TB] FAIL noconfig_latency: got %0d expected 8", lat);
    end
    checks++;
    if (res !== 8'h00) begin
      errors++;
      $display("[TB] FAIL noconfig_data: got %h expected 00", res);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL noconfig_return_idle: got in_ready=%b expected 1", in_ready);
    end
  endtask

  task automatic test_directed();
    logic [7:0] res;
    int lat;
    write_cfg(3'd0, 64'h0000_0000_0000_0001);
    write_cfg(3'd7, 64'h8000_0000_0000_0000);
    run_vector({6'd63, 36'd0, 6'd0}, 1'b0, 3'd0, 64'd0, 1'b1, res, lat);
    checks++;
    if (lat != 8 || res !== 8'h81) begin
      errors++;
      $display("[TB] FAIL directed_81: got data=%h lat=%0d expected data=81 lat=8", res, lat);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] res;
    int lat;
    logic [47:0] v;
    v = {6'd63, 18'd0, 6'd5, 12'd0, 6'd0};
    run_vector(v, 1'b0, 3'd0, 64'd0, 1'b0, res, lat);
    checks++;
    if (lat != 8 || res !== 8'h81) begin
      errors++;
      $display("[TB] FAIL bp_first: got data=%h lat=%0d expected data=81 lat=8", res, lat);
    end
    for (int i = 0; i < 20; i++) begin
      cfg_we = (i < 5); cfg_addr = 3'd3; cfg_data = '1;
      @(negedge clk);
      checks++;
      if (out_data !== 8'h81 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL bp_hold[%0d]: got data=%h valid=%b in_ready=%b expected 81 1 0",
                 i, out_data, out_valid, in_ready);
      end
    end
    cfg_we = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_release: got in_ready=%b valid=%b expected 1 0", in_ready, out_valid);
    end
    run_vector(v, 1'b0, 3'd0, 64'd0, 1'b1, res, lat);
    checks++;
    if (lat != 8 || res !== 8'h81) begin
      errors++;
      $display("[TB] FAIL bp_write_ignored: got data=%h lat=%0d expected data=81 lat=8", res, lat);
    end
  endtask

  task automatic test_simultaneous();
    logic [7:0] res;
    int lat;
    run_vector({6'd63, 36'd0, 6'd0}, 1'b1, 3'd2, '1, 1'b1, res, lat);
    mtab[2] = '1;
    checks++;
    if (lat != 8 || res !== 8'h85) begin
      errors++;
      $display("[TB] FAIL simultaneous_cfg: got data=%h lat=%0d expected data=85 lat=8", res, lat);
    end
  endtask

  task automatic test_cfg_range();
    int lat;
    logic [4:0] res;
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 0) begin
        for (int a = 5; a < 8; a++) begin
          s_cfg_we = 1'b1; s_cfg_addr = 3'(a); s_cfg_data = '1;
          @(negedge clk);
        end
      end else begin
        s_cfg_we = 1'b1; s_cfg_addr = 3'd4; s_cfg_data = '1;
        @(negedge clk);
      end
      s_cfg_we = 1'b0;
      s_in_valid = 1'b1; s_in_data = '1;
      lat = -1;
      res = 'x;
      for (int c = 0; c < 100; c++) begin
        @(negedge clk);
        if (c == 0) s_in_valid = 1'b0;
        if (s_out_valid) begin
          lat = c;
          res = s_out_data;
          break;
        end
      end
      @(negedge clk);
      checks++;
      if (lat != 5 || res !== ((pass == 0) ? 5'h00 : 5'h10)) begin
        errors++;
        $display("[TB] FAIL cfg_range_pass%0d: got data=%h lat=%0d expected data=%h lat=5",
                 pass, res, lat, (pass == 0) ? 5'h00 : 5'h10);
      end
    end
  endtask

  task automatic test_reset_mid_eval();
    logic [7:0] res;
    int lat;
    int seen;
    logic [47:0] v;
    v = {6'd63, 36'd0, 6'd0};
    in_valid = 1'b1; in_data = v;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (out_data !== 8'h05 || out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_eval_partial: got data=%h valid=%b expected 05 0", out_data, out_valid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_data !== 8'h00 || out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_eval_async_clear: got data=%h valid=%b expected 00 0", out_data, out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < N; k++) mtab[k] = '0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_eval_ready: got in_ready=%b expected 1", in_ready);
    end
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) seen++;
      @(negedge clk);
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("[TB] FAIL mid_eval_no_output: got %0d valid cycles expected 0", seen);
    end
    run_vector(v, 1'b0, 3'd0, 64'd0, 1'b1, res, lat);
    checks++;
    if (lat != 8 || res !== 8'h00) begin
      errors++;
      $display("[TB] FAIL mid_eval_tables_cleared: got data=%h lat=%0d expected data=00 lat=8", res, lat);
    end
  endtask

  task automatic test_back_to_back();
    int acc [$];
    int bad;
    write_cfg(3'd1, '1);
    in_valid = 1'b1; in_data = '0; out_ready = 1'b1;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      if (in_ready) acc.push_back(i);
      if (out_valid && out_data !== 8'h02) bad++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (12) @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (acc.size() < 3) begin
      errors++;
      $display("[TB] FAIL b2b_accepts: got %0d accepts expected at least 3", acc.size());
    end else begin
      checks++;
      if (acc[1] - acc[0] != 10 || acc[2] - acc[1] != 10) begin
        errors++;
        $display("[TB] FAIL b2b_interval: got %0d,%0d cycles expected 10,10",
                 acc[1] - acc[0], acc[2] - acc[1]);
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("[TB] FAIL b2b_data: got %0d wrong results expected 0", bad);
    end
  endtask

  task automatic test_random();
    logic [7:0] res, exp;
    logic [63:0] r, cd;
    logic [2:0] ca;
    logic [47:0] v;
    int lat, base, h;
    bit cw;
    do_reset();
    for (int k = 0; k < N; k++) write_cfg(3'(k), {$urandom, $urandom});
    base = hs_count;
    for (int n = 0; n < 100; n++) begin
      r = {$urandom, $urandom};
      v = r[47:0];
      cw = (n % 25 == 0);
      ca = 3'($urandom_range(0, 7));
      cd = {$urandom, $urandom};
      if (cw) mtab[ca] = cd;
      exp = model_eval(v);
      run_vector(v, cw, ca, cd, 1'b0, res, lat);
      checks++;
      if (lat != 8 || res !== exp) begin
        errors++;
        $display("[TB] FAIL random[%0d]: got data=%h lat=%0d expected data=%h lat=8", n, res, lat, exp);
      end
      if (lat >= 0) begin
        h = $urandom_range(0, 3);
        repeat (h) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
      end
    end
    @(negedge clk);
    checks++;
    if (hs_count - base != 100) begin
      errors++;
      $display("[TB] FAIL random_count: got %0d handshakes expected 100", hs_count - base);
    end
  endtask

  initial begin
    test_reset();
    test_no_config();
    test_directed();
    test_backpressure();
    test_simultaneous();
    test_cfg_range();
    test_reset_mid_eval();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
